jtag_tap_controller: RTL and testbench

// - IEEE 1149.1 TAP controller + instruction register + bypass register driving the boundary-scan chain.
// - Generates ShiftDR/ClockDR/UpdateDR/Mode for every boundary scan cell.
// - Receives the chain's serial return (last cell's to_next_cell) and muxes it onto TDO.
// - Sits between the chip JTAG pins and the boundary-scan register (BSR).

---
 rtl/jtag_tap_controller.sv | 184 ++++++++++++++++++
 tb/tb_jtag_tap_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller with instruction and bypass registers, driving a boundary-scan chain.
// Optional 32-bit IDCODE register enabled by defining JTAG_IDCODE_EN.
module jtag_tap_controller #(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST  = IR_WIDTH'(4'b0000),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE  = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE  = IR_WIDTH'(4'b0010),
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       bsr_tdo,
  output logic       TDO,
  output logic       TDO_en,
  output logic       bsr_tdi,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Mode,
  output logic [3:0] tap_state
);

  typedef enum logic [3:0] {
    ST_EX2DR = 4'h0, ST_EX1DR = 4'h1, ST_SHDR  = 4'h2, ST_PSDR  = 4'h3,
    ST_SELIR = 4'h4, ST_UPDDR = 4'h5, ST_CAPDR = 4'h6, ST_SELDR = 4'h7,
    ST_EX2IR = 4'h8, ST_EX1IR = 4'h9, ST_SHIR  = 4'hA, ST_PSIR  = 4'hB,
    ST_RTI   = 4'hC, ST_UPDIR = 4'hD, ST_CAPIR = 4'hE, ST_TLR   = 4'hF
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                shift_dr_q, shift_dr_d;
  logic                update_dr_q, update_dr_d;
  logic                mode_q, mode_d;
  logic                clk_en_q, clk_en_d;
  logic                bsr_sel_c, id_sel_c, id_tdo_c, dr_tdo_c, dr_active_c;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_OP = OP_IDCODE;
  logic [31:0] id_q, id_d;

  // Device ID register: captures the ID value, then shifts LSB first
  always_comb begin
    id_d = id_q;
    if (state_q == ST_CAPDR)     id_d = IDCODE_VAL;
    else if (state_q == ST_SHDR) id_d = {TDI, id_q[31:1]};
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) id_q <= IDCODE_VAL;
    else         id_q <= id_d;
  end

  assign id_sel_c = (ir_q == OP_IDCODE);
  assign id_tdo_c = id_q[0];
`else
  localparam logic [IR_WIDTH-1:0] RST_OP = '1;
  logic unused_id_c;
  assign unused_id_c = ^{IDCODE_VAL, OP_IDCODE};
  assign id_sel_c    = 1'b0;
  assign id_tdo_c    = 1'b0;
`endif

  assign bsr_sel_c   = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
  assign dr_tdo_c    = bsr_sel_c ? bsr_tdo : (id_sel_c ? id_tdo_c : bypass_q);
  assign dr_active_c = ((state_q == ST_CAPDR) || (state_q == ST_SHDR)) && bsr_sel_c;

  // TAP state transitions from TMS
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:   state_d = TMS ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = TMS ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = TMS ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = TMS ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = TMS ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = TMS ? ST_UPDDR : ST_PSDR;
      ST_PSDR:  state_d = TMS ? ST_EX2DR : ST_PSDR;
      ST_EX2DR: state_d = TMS ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: state_d = TMS ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = TMS ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = TMS ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = TMS ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = TMS ? ST_UPDIR : ST_PSIR;
      ST_PSIR:  state_d = TMS ? ST_EX2IR : ST_PSIR;
      ST_EX2IR: state_d = TMS ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: state_d = TMS ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  // Rising-edge capture/shift of IR and bypass registers
  always_comb begin
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    case (state_q)
      ST_CAPIR: ir_shift_d = IR_WIDTH'(2'b01);
      ST_SHIR:  ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      ST_CAPDR: bypass_d   = 1'b0;
      ST_SHDR:  bypass_d   = TDI;
      default: ;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      state_q    <= ST_TLR;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

  // Falling-edge outputs: active instruction, Mode, TDO and DR strobes
  always_comb begin
    ir_d        = ir_q;
    mode_d      = mode_q;
    tdo_d       = 1'b0;
    tdo_en_d    = 1'b0;
    shift_dr_d  = (state_q == ST_SHDR)  && bsr_sel_c;
    update_dr_d = (state_q == ST_UPDDR) && bsr_sel_c;
    clk_en_d    = dr_active_c;
    case (state_q)
      ST_TLR: begin
        ir_d   = RST_OP;
        mode_d = 1'b0;
      end
      ST_UPDIR: begin
        ir_d   = ir_shift_q;
        mode_d = (ir_shift_q == OP_EXTEST);
      end
      ST_SHIR: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      ST_SHDR: begin
        tdo_d    = dr_tdo_c;
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      ir_q        <= RST_OP;
      mode_q      <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      shift_dr_q  <= 1'b0;
      update_dr_q <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      mode_q      <= mode_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      shift_dr_q  <= shift_dr_d;
      update_dr_q <= update_dr_d;
      clk_en_q    <= clk_en_d;
    end
  end

  // Enable is also qualified by the state (which changes only while TCK is high),
  // so the falling edge of clk_en_q at a TCK negedge cannot produce a runt low pulse.
  assign ClockDR   = TCK | ~(clk_en_q & dr_active_c);
  assign bsr_tdi   = TDI;
  assign TDO       = tdo_q;
  assign TDO_en    = tdo_en_q;
  assign ShiftDR   = shift_dr_q;
  assign UpdateDR  = update_dr_q;
  assign Mode      = mode_q;
  assign tap_state = 4'(state_q);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed testbench for jtag_tap_controller: TAP walks, IR/DR scans, async reset and BSR strobes.
module tb_jtag_tap_controller;

  logic       TCK, TRST_n, TMS, TDI, bsr_tdo;
  logic       TDO, TDO_en, bsr_tdi, ShiftDR, ClockDR, UpdateDR, Mode;
  logic [3:0] tap_state;

  int passed = 0;
  int total  = 0;
  int sh0    = 0;
  int sh1    = 0;
  int upd    = 0;

  jtag_tap_controller dut (
    .TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
    .TDO(TDO), .TDO_en(TDO_en), .bsr_tdi(bsr_tdi), .ShiftDR(ShiftDR),
    .ClockDR(ClockDR), .UpdateDR(UpdateDR), .Mode(Mode), .tap_state(tap_state)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // A low ClockDR during a TCK-low phase means a ClockDR rise at the next TCK posedge
  always @(negedge TCK) begin
    #1;
    if (ClockDR === 1'b0) begin
      if (ShiftDR === 1'b1) sh1++;
      else                  sh0++;
    end
  end

  always @(posedge UpdateDR) upd++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pos(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic neg();
    @(negedge TCK);
    #1;
  endtask

  task automatic step(input logic tms, input logic tdi);
    pos(tms, tdi);
    neg();
  endtask

  // From RTI: scan op into IR, LSB first, ending in Exit1-IR; returns bits seen on TDO
  task automatic ir_scan(input logic [3:0] op, output logic [3:0] out);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      out[i] = TDO;
      step(i == 3, op[i]);
    end
  endtask

  initial begin
    logic [3:0]  irout;
    logic [31:0] idv;
    int s0, s1, u;

    TRST_n  = 1'b0;
    TMS     = 1'b1;
    TDI     = 1'b0;
    bsr_tdo = 1'b1;
    #12;
    check("rst_state",    32'(tap_state), 32'hF);
    check("rst_tdo",      32'(TDO),       32'h0);
    check("rst_tdo_en",   32'(TDO_en),    32'h0);
    check("rst_shiftdr",  32'(ShiftDR),   32'h0);
    check("rst_updatedr", 32'(UpdateDR),  32'h0);
    check("rst_mode",     32'(Mode),      32'h0);
    check("rst_clockdr",  32'(ClockDR),   32'h1);
    TDI = 1'b1;
    #1;
    check("bsr_tdi_pass", 32'(bsr_tdi), 32'h1);
    TDI    = 1'b0;
    TRST_n = 1'b1;
    neg();

    step(1'b0, 1'b0);
    check("tlr_to_rti", 32'(tap_state), 32'hC);
    repeat (5) step(1'b1, 1'b0);
    check("tms5_to_tlr", 32'(tap_state), 32'hF);
    step(1'b0, 1'b0);
    check("tlr_back_rti", 32'(tap_state), 32'hC);

    // Load EXTEST; Mode must switch only at the Update-IR falling edge
    ir_scan(4'b0000, irout);
    check("ir_capture_out", 32'(irout), 32'h1);
    check("ex1ir_tdo_en", 32'(TDO_en), 32'h0);
    pos(1'b1, 1'b0);
    check("updir_state",   32'(tap_state), 32'hD);
    check("mode_before_upd", 32'(Mode), 32'h0);
    neg();
    check("mode_after_upd",  32'(Mode), 32'h1);
    step(1'b0, 1'b0);

    // Enter Shift-DR under EXTEST, then async reset mid-shift
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("extest_shdr_state", 32'(tap_state), 32'h2);
    check("extest_shiftdr",    32'(ShiftDR),   32'h1);
    check("extest_mode_in_dr", 32'(Mode),      32'h1);
    check("extest_clockdr_lo", 32'(ClockDR),   32'h0);
    check("extest_tdo_en",     32'(TDO_en),    32'h1);
    TRST_n = 1'b0;
    #1;
    check("trst_state",   32'(tap_state), 32'hF);
    check("trst_mode",    32'(Mode),      32'h0);
    check("trst_tdo_en",  32'(TDO_en),    32'h0);
    check("trst_clockdr", 32'(ClockDR),   32'h1);
    check("trst_shiftdr", 32'(ShiftDR),   32'h0);
    #1;
    TRST_n = 1'b1;

    // DR scan with the reset instruction selected
    step(1'b0, 1'b0);
    s0 = sh0;
    s1 = sh1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
    for (int i = 0; i < 32; i++) begin
      idv[i] = TDO;
      step(i == 31, 1'b0);
    end
    check("idcode_scan", idv, 32'h1000_0001);
`else
    idv = 32'h0;
    check("rstop_tdo0", 32'(TDO), 32'h0);
    step(1'b0, 1'b1);
    check("rstop_tdo1", 32'(TDO), 32'h1);
    step(1'b0, 1'b0);
    check("rstop_tdo2", 32'(TDO), 32'h0);
    step(1'b1, 1'b0);
    check("rstop_id_unused", idv, 32'h0);
`endif
    check("rstop_no_clockdr", 32'((sh0 + sh1) - (s0 + s1)), 32'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // SAMPLE/PRELOAD and a 3-shift BSR scan
    ir_scan(4'b0001, irout);
    check("ir_capture_out2", 32'(irout), 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("sample_mode", 32'(Mode), 32'h0);
    s0 = sh0;
    s1 = sh1;
    u  = upd;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("capdr_state",    32'(tap_state), 32'h6);
    check("capdr_shiftdr",  32'(ShiftDR),   32'h0);
    step(1'b0, 1'b0);
    check("sample_shiftdr", 32'(ShiftDR), 32'h1);
    check("sample_tdo",     32'(TDO),     32'h1);
    check("sample_tdo_en",  32'(TDO_en),  32'h1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("ex1dr_shiftdr",  32'(ShiftDR), 32'h0);
    step(1'b1, 1'b0);
    check("upddr_pulse_hi", 32'(UpdateDR), 32'h1);
    step(1'b0, 1'b0);
    check("upddr_pulse_lo", 32'(UpdateDR), 32'h0);
    check("sample_mode_end", 32'(Mode), 32'h0);
    check("capture_rises", 32'(sh0 - s0), 32'h1);
    check("shift_rises",   32'(sh1 - s1), 32'h3);
    check("update_pulses", 32'(upd - u),  32'h1);

    // Explicit BYPASS: one-cycle TDI->TDO delay, no BSR clocking
    ir_scan(4'b1111, irout);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    s0 = sh0;
    s1 = sh1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("byp_tdo0",    32'(TDO),     32'h0);
    check("byp_clockdr", 32'(ClockDR), 32'h1);
    step(1'b0, 1'b1);
    check("byp_tdo1",    32'(TDO),     32'h1);
    step(1'b0, 1'b0);
    check("byp_tdo2",    32'(TDO),     32'h0);
    step(1'b1, 1'b1);
    check("byp_ex1_tdo_en",  32'(TDO_en), 32'h0);
    check("byp_no_clockdr",  32'((sh0 + sh1) - (s0 + s1)), 32'h0);
    check("byp_shiftdr",     32'(ShiftDR), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
